mprj_reset_sequencer: RTL and testbench

Parametrised multi-stage reset sequencer for the user project area, generalising the single fixed 4095-cycle core reset stretcher.
- Holds N downstream reset domains (core, SPI flash, UART, off-chip bus) in reset for a programmable time.
- Releases the domains in a fixed order with a programmable gap between them.
- Gates pad output enables until every domain is out of reset.
- Accepts a software/LA reset request and an optional watchdog that re-runs the whole sequence.

---
 rtl/mprj_reset_sequencer_pkg.sv | 15 +
 rtl/mprj_reset_sequencer_sync_2ff.sv | 25 ++
 rtl/mprj_reset_sequencer.sv | 142 ++++++++++++++
 tb/tb_mprj_reset_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mprj_reset_sequencer_pkg.sv
// Shared types for the user-project reset sequencer.
// State encoding and index-width helper.
package mprj_rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } rst_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mprj_reset_sequencer_sync_2ff.sv
// Two-flop level synchroniser for an asynchronous request.
// Resets to 0 so a stale request cannot leak out of reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/mprj_reset_sequencer.sv
// Staged reset release for the user project domains with pad oe gating.
// Optional watchdog re-run enabled by defining MPRJ_RST_WDT_EN.
module mprj_reset_sequencer
  import mprj_rst_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 4095,
  parameter int STAGE_GAP   = 16,
  parameter int CNT_W       = 12,
  parameter int WDT_TIMEOUT = 4000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  io_oe_gate,
  output logic                  busy,
  output logic                  done
`ifdef MPRJ_RST_WDT_EN
  ,input  logic                 wdt_kick
  ,output logic                 wdt_fired
`endif
);

  localparam int IW = idx_w(NUM_STAGES);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(STAGE_GAP);
  localparam logic [IW-1:0]    LAST   = IW'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || STAGE_GAP < 1 || HOLD_CYCLES < 0 ||
      WDT_TIMEOUT < 1 ||
      HOLD_CYCLES >= (1 << CNT_W) ||
      STAGE_GAP >= (1 << CNT_W) ||
      WDT_TIMEOUT >= (1 << CNT_W)) begin : g_bad_cfg
    $error("mprj_reset_sequencer: bad parameters");
  end

  rst_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IW-1:0]         idx_q;
  logic [NUM_STAGES-1:0] srn_q;
  logic                  gate_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  req_s;
  logic                  abort;

  sync_2ff u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (sw_rst_req),
    .q_o (req_s)
  );

`ifdef MPRJ_RST_WDT_EN
  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_TIMEOUT - 1);

  logic [CNT_W-1:0] wdt_q;
  logic             fired_q;
  logic             wdt_to;

  assign wdt_to = (state_q == RUN) && (wdt_q == WDT_LAST) && !wdt_kick;
  assign abort  = (req_s && (state_q != HOLD)) || wdt_to;
  assign wdt_fired = fired_q;
`else
  assign abort = req_s && (state_q != HOLD);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      srn_q   <= '0;
      gate_q  <= 1'b1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef MPRJ_RST_WDT_EN
      wdt_q   <= '0;
      fired_q <= 1'b0;
`endif
    end else begin
`ifdef MPRJ_RST_WDT_EN
      fired_q <= wdt_to;
      if (state_q != RUN || abort || wdt_kick) begin
        wdt_q <= '0;
      end else begin
        wdt_q <= wdt_q + CNT_W'(1);
      end
`endif
      // Abort drops every domain at once; no staged shutdown.
      if (abort) begin
        state_q <= HOLD;
        cnt_q   <= '0;
        idx_q   <= '0;
        srn_q   <= '0;
        gate_q  <= 1'b1;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        unique case (state_q)
          HOLD: begin
            if (req_s) begin
              cnt_q <= '0;
            end else if (cnt_q == HOLD_C) begin
              srn_q[0] <= 1'b1;
              cnt_q    <= CNT_W'(1);
              idx_q    <= IW'(1);
              state_q  <= (NUM_STAGES == 1) ? RUN : RELEASE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          RELEASE: begin
            if (cnt_q == GAP_C) begin
              srn_q[idx_q] <= 1'b1;
              idx_q        <= idx_q + IW'(1);
              cnt_q        <= CNT_W'(1);
              if (idx_q == LAST) begin
                state_q <= RUN;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          RUN: begin
            gate_q <= 1'b0;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
          default: state_q <= HOLD;
        endcase
      end
    end
  end

  assign stage_rst_n = srn_q;
  assign io_oe_gate  = gate_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mprj_reset_sequencer.sv
// Scoreboard bench for mprj_reset_sequencer (main and corner configs).
// Watchdog scenario included when MPRJ_RST_WDT_EN is defined.
module tb_mprj_reset_sequencer;

  typedef struct {
    int         cyc;
    bit         unit;
    logic [2:0] srn;
    logic       gate;
    logic       done;
    logic       busy;
    bit         chk_f;
    logic       fired;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   = 1'b1;
  logic       rst_c = 1'b1;
  logic       sw    = 1'b0;
  logic       sw_c  = 1'b0;
  logic [2:0] srn;
  logic       gate, busy, done;
  logic [0:0] srn_c;
  logic       gate_c, busy_c, done_c;
`ifdef MPRJ_RST_WDT_EN
  logic kick   = 1'b1;
  logic kick_c = 1'b1;
  logic fired, fired_c;
`endif

  mprj_reset_sequencer #(
    .NUM_STAGES(3), .HOLD_CYCLES(8), .STAGE_GAP(3),
    .CNT_W(12), .WDT_TIMEOUT(10)
  ) u_dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw),
    .stage_rst_n(srn), .io_oe_gate(gate),
    .busy(busy), .done(done)
`ifdef MPRJ_RST_WDT_EN
    ,.wdt_kick(kick), .wdt_fired(fired)
`endif
  );

  mprj_reset_sequencer #(
    .NUM_STAGES(1), .HOLD_CYCLES(0), .STAGE_GAP(3),
    .CNT_W(12), .WDT_TIMEOUT(10)
  ) u_corner (
    .clk(clk), .rst(rst_c), .sw_rst_req(sw_c),
    .stage_rst_n(srn_c), .io_oe_gate(gate_c),
    .busy(busy_c), .done(done_c)
`ifdef MPRJ_RST_WDT_EN
    ,.wdt_kick(kick_c), .wdt_fired(fired_c)
`endif
  );

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(exp_t e);
    int i;
    i = q.size();
    while (i > 0 && q[i-1].cyc > e.cyc) i--;
    q.insert(i, e);
  endfunction

  function automatic void ex(bit u, int c, logic [2:0] s,
                             logic g, logic d, logic b, string n);
    exp_t e;
    e.cyc = c; e.unit = u; e.srn = s;
    e.gate = g; e.done = d; e.busy = b;
    e.chk_f = 1'b0; e.fired = 1'b0; e.name = n;
    push(e);
  endfunction

  function automatic void exf(int c, logic [2:0] s, logic g,
                              logic d, logic b, logic f, string n);
    exp_t e;
    e.cyc = c; e.unit = 1'b0; e.srn = s;
    e.gate = g; e.done = d; e.busy = b;
    e.chk_f = 1'b1; e.fired = f; e.name = n;
    push(e);
  endfunction

  task automatic check(input exp_t e);
    logic [2:0] a_srn;
    logic       a_g, a_d, a_b;
    if (e.unit) begin
      a_srn = {2'b00, srn_c}; a_g = gate_c; a_d = done_c; a_b = busy_c;
    end else begin
      a_srn = srn; a_g = gate; a_d = done; a_b = busy;
    end
    checks++;
    if (e.cyc != cyc) begin
      failures++;
      $display("FAIL %s missed: at cyc=%0d, required cyc=%0d",
               e.name, cyc, e.cyc);
    end else if ({a_srn, a_g, a_d, a_b} !== {e.srn, e.gate, e.done, e.busy}) begin
      failures++;
      $display("FAIL %s cyc=%0d got srn=%b gate=%b done=%b busy=%b want srn=%b gate=%b done=%b busy=%b",
               e.name, cyc, a_srn, a_g, a_d, a_b, e.srn, e.gate, e.done, e.busy);
    end
`ifdef MPRJ_RST_WDT_EN
    if (e.chk_f) begin
      checks++;
      if (fired !== e.fired) begin
        failures++;
        $display("FAIL %s cyc=%0d got wdt_fired=%b want %b",
                 e.name, cyc, fired, e.fired);
      end
    end
`endif
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        check(e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int e0;
    tick(2);

    // Basic sequence, with reset values checked first
    ex(0, cyc + 1, 3'b000, 1, 0, 1, "rst_vals");
    tick(2);
    rst = 1'b0; e0 = cyc;
    ex(0, e0 + 1,  3'b000, 1, 0, 1, "s1_hold");
    ex(0, e0 + 8,  3'b000, 1, 0, 1, "s1_pre0");
    ex(0, e0 + 9,  3'b001, 1, 0, 1, "s1_st0");
    ex(0, e0 + 11, 3'b001, 1, 0, 1, "s1_pre1");
    ex(0, e0 + 12, 3'b011, 1, 0, 1, "s1_st1");
    ex(0, e0 + 14, 3'b011, 1, 0, 1, "s1_pre2");
    ex(0, e0 + 15, 3'b111, 1, 0, 1, "s1_st2");
    ex(0, e0 + 16, 3'b111, 0, 1, 0, "s1_run");
    tick(20);

    // One-cycle request pulse while running
    e0 = cyc; sw = 1'b1;
    ex(0, e0 + 2,  3'b111, 0, 1, 0, "s3_sync");
    ex(0, e0 + 3,  3'b000, 1, 0, 1, "s3_abort");
    ex(0, e0 + 11, 3'b000, 1, 0, 1, "s3_pre0");
    ex(0, e0 + 12, 3'b001, 1, 0, 1, "s3_st0");
    ex(0, e0 + 15, 3'b011, 1, 0, 1, "s3_st1");
    ex(0, e0 + 18, 3'b111, 1, 0, 1, "s3_st2");
    ex(0, e0 + 19, 3'b111, 0, 1, 0, "s3_run");
    tick(1); sw = 1'b0;
    tick(24);

    // Request landing on the same edge as stage 1 release
    rst = 1'b1; tick(2); rst = 1'b0; e0 = cyc;
    ex(0, e0 + 11, 3'b001, 1, 0, 1, "s5_pre");
    ex(0, e0 + 12, 3'b000, 1, 0, 1, "s5_abort_wins");
    ex(0, e0 + 21, 3'b001, 1, 0, 1, "s5_st0");
    ex(0, e0 + 28, 3'b111, 0, 1, 0, "s5_run");
    tick(9); sw = 1'b1;
    tick(1); sw = 1'b0;
    tick(20);

    // Request held from reset release
    rst = 1'b1; sw = 1'b1; tick(2); rst = 1'b0; e0 = cyc;
    ex(0, e0 + 10, 3'b000, 1, 0, 1, "s2_held10");
    ex(0, e0 + 20, 3'b000, 1, 0, 1, "s2_held20");
    tick(20);
    sw = 1'b0; e0 = cyc;
    ex(0, e0 + 10, 3'b000, 1, 0, 1, "s2_pre0");
    ex(0, e0 + 11, 3'b001, 1, 0, 1, "s2_st0");
    ex(0, e0 + 14, 3'b011, 1, 0, 1, "s2_st1");
    ex(0, e0 + 17, 3'b111, 1, 0, 1, "s2_st2");
    ex(0, e0 + 18, 3'b111, 0, 1, 0, "s2_run");
    tick(22);

    // rst pulse in the middle of RELEASE
    rst = 1'b1; tick(2); rst = 1'b0; e0 = cyc;
    ex(0, e0 + 13, 3'b011, 1, 0, 1, "s4_mid");
    tick(13);
    rst = 1'b1;
    ex(0, e0 + 14, 3'b000, 1, 0, 1, "s4_rst");
    tick(1);
    rst = 1'b0; e0 = cyc;
    ex(0, e0 + 8,  3'b000, 1, 0, 1, "s4_pre0");
    ex(0, e0 + 9,  3'b001, 1, 0, 1, "s4_st0");
    ex(0, e0 + 15, 3'b111, 1, 0, 1, "s4_st2");
    ex(0, e0 + 16, 3'b111, 0, 1, 0, "s4_run");
    tick(20);

    // HOLD_CYCLES=0, NUM_STAGES=1
    ex(1, cyc + 1, 3'b000, 1, 0, 1, "c_rst_vals");
    tick(2);
    rst_c = 1'b0; e0 = cyc;
    ex(1, e0 + 1, 3'b001, 1, 0, 1, "c_st0");
    ex(1, e0 + 2, 3'b001, 0, 1, 0, "c_run");
    ex(1, e0 + 5, 3'b001, 0, 1, 0, "c_stay");
    tick(6);

`ifdef MPRJ_RST_WDT_EN
    // Watchdog: no kick fires once, then periodic kicks hold it off
    rst = 1'b1; tick(2); rst = 1'b0; kick = 1'b0; e0 = cyc;
    exf(e0 + 24, 3'b111, 0, 1, 0, 1'b0, "w_pre");
    exf(e0 + 25, 3'b000, 1, 0, 1, 1'b1, "w_fire");
    exf(e0 + 26, 3'b000, 1, 0, 1, 1'b0, "w_pulse1");
    exf(e0 + 41, 3'b111, 0, 1, 0, 1'b0, "w_rerun");
    exf(e0 + 55, 3'b111, 0, 1, 0, 1'b0, "w_kick55");
    exf(e0 + 65, 3'b111, 0, 1, 0, 1'b0, "w_kick65");
    exf(e0 + 75, 3'b111, 0, 1, 0, 1'b0, "w_kick75");
    tick(26);
    for (int i = 0; i < 54; i++) begin
      kick = ((cyc - e0) % 5 == 0);
      tick(1);
    end
    kick = 1'b1;
    tick(2);
`endif

    tick(3);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s pending: cyc=%0d never reached", e.name, e.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
